rv_mem_arbiter: RTL and testbench
=================================

# rv_mem_arbiter

Single-port memory arbiter placed between the fetch stage, the load/store unit and one synchronous SRAM (1-cycle read latency). It shares the memory between the instruction stream and data accesses. Data accesses have priority. The fetch stage sees a lost slot as `im_valid_o = 0` and re-presents the same address on the next cycle. An optional starvation guard bounds how long data traffic can hold off instruction fetch.

## Interface
- `MAX_DATA_RUN`, default 4: number of consecutive data grants allowed before one fetch slot is forced; legal range 1..15. Used only with `RV_ARB_FAIRNESS_EN`.

Ports:
- `clk_i` in 1: clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `im_addr_i` in 32: fetch address for the current cycle; fetch is always treated as requesting.
- `im_data_o` out 32: instruction word; equals `mem_rdata_i`.
- `im_valid_o` out 1: `im_data_o` holds the word for the address fetched in the previous cycle.
- `dm_req_i` in 1: data access request.
- `dm_we_i` in 1: 1 = store, 0 = load.
- `dm_addr_i` in 32: data address.
- `dm_wdata_i` in 32: store data.
- `dm_be_i` in 4: store byte enables.
- `dm_gnt_o` out 1: request accepted this cycle (combinational).
- `dm_rdata_o` out 32: load data; equals `mem_rdata_i`.
- `dm_rvalid_o` out 1: load data valid; one cycle after the load's grant.
- `mem_addr_o` out 32: SRAM address; word-aligned, bits [1:0] forced to 0.
- `mem_wdata_o` out 32: SRAM write data.
- `mem_we_o` out 4: SRAM byte write enables.
- `mem_rdata_i` in 32: SRAM read data, valid the cycle after the address.

## Operation
- Registered FSM `owner_q` records who used the memory in the previous cycle. States:
  - `OWN_NONE`: reset state.
  - `OWN_FETCH`
  - `OWN_LOAD`
  - `OWN_STORE`
- Each cycle the arbiter grants exactly one requester:
  - Data is granted when `dm_req_i = 1`, unless the fairness guard blocks it.
  - Fetch gets the slot otherwise.
- Data grant, cycle N:
  - `dm_gnt_o = 1`, `mem_addr_o = dm_addr_i`.
  - Store: `mem_we_o = dm_be_i`, `mem_wdata_o = dm_wdata_i`; `owner_q` becomes `OWN_STORE`.
  - Load: `mem_we_o = 0`; `owner_q` becomes `OWN_LOAD`.
- Fetch slot, cycle N: `mem_addr_o = im_addr_i`, `mem_we_o = 0`, `dm_gnt_o = 0`; `owner_q` becomes `OWN_FETCH`.
- Outputs decoded from `owner_q`, cycle N+1:
  - `im_valid_o = (owner_q == OWN_FETCH)`.
  - `dm_rvalid_o = (owner_q == OWN_LOAD)`.
  - Stores complete at grant and produce no `dm_rvalid_o`.
- `mem_wdata_o` is `dm_wdata_i` when data owns the slot, 0 otherwise.
- Requester rules:
  - The requester holds `dm_req_i` and its payload until it sees `dm_gnt_o`.
  - It may present a new request in the cycle right after the grant.
  - `dm_req_i` may not be withdrawn before grant.

## Timing
- Reset (async assert, synchronous release):
  - `owner_q = OWN_NONE`, so `im_valid_o = 0` and `dm_rvalid_o = 0`.
  - Run counter = 0.
  - Combinational outputs follow their inputs; `mem_we_o = 0` whenever `dm_req_i = 0`.
- Latency is 1 cycle from address to `im_valid_o` or `dm_rvalid_o`. Grant latency is 0 cycles.
- First cycle after reset release: fetch is granted if `dm_req_i = 0`, giving `im_valid_o = 1` one cycle later.
- Data request and fetch in the same cycle: data wins. The fetch address is dropped, giving `im_valid_o = 0` next cycle.
- Back-to-back loads and stores are allowed at one per cycle.
- Reset asserted mid-access: any pending `dm_rvalid_o` or `im_valid_o` is lost. The requester must reissue after reset.
- Address bits [1:0] are ignored and no misalignment is reported.

## Configuration
- `RV_ARB_FAIRNESS_EN` defined:
  - A 4-bit run counter increments on each data grant and clears on each fetch slot.
  - When the counter equals `MAX_DATA_RUN`, `dm_gnt_o` is forced to 0 for one cycle and fetch takes the slot.
  - The counter saturates at `MAX_DATA_RUN`; it never wraps.
- Undefined: no counter. Data has strict priority and fetch can starve indefinitely while `dm_req_i` stays 1.

## Structure
- Shared package `rv_arb_pkg` holds:
  - `rv_arb_owner_t`, a 2-bit enum with `OWN_NONE=0`, `OWN_FETCH=1`, `OWN_LOAD=2`, `OWN_STORE=3`.
  - Constant `RV_ARB_RUN_W = 4`.
- One sub-module, `rv_arb_run_cnt`, holds the saturating run counter and its block flag. It is instantiated only under `RV_ARB_FAIRNESS_EN`.

## Test plan
- Reset and idle:
  - Hold `rst_n_i = 0` and check `im_valid_o = 0`, `dm_rvalid_o = 0`.
  - Release with `dm_req_i = 0` and `im_addr_i = 0x0`; expect `mem_addr_o = 0x0` and `im_valid_o = 1` one cycle later.
- Load collides with fetch:
  - Set `im_addr_i = 0x100`, load at `0x2004`.
  - Expect `dm_gnt_o = 1` and `mem_addr_o = 0x2004`.
  - Next cycle expect `dm_rvalid_o = 1` with SRAM data, and `im_valid_o = 0`.
  - Fetch of `0x100` is granted on the following cycle.
- Store:
  - Store `0xDEADBEEF`, `dm_be_i = 4'b0011`, to `0x3002`.
  - Expect `mem_addr_o = 0x3000`, `mem_we_o = 4'b0011` for one cycle.
  - Expect no `dm_rvalid_o` and `im_valid_o = 0` the next cycle.
- Fairness guard, with `RV_ARB_FAIRNESS_EN` and `MAX_DATA_RUN = 4`:
  - Hold `dm_req_i = 1` for 12 cycles.
  - Expect the grant pattern 4 data, 1 fetch, 4 data, 1 fetch, 2 data.
  - Expect `im_valid_o` pulses one cycle after each fetch slot.
- Macro off: hold `dm_req_i = 1` for 12 cycles; expect 12 data grants and `im_valid_o = 0` throughout.
- Async reset mid-load: deassert `rst_n_i` between a load grant and its result; expect `dm_rvalid_o = 0` immediately, with no clock edge needed.

Source files
------------

// File: rtl/rv_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package rv_arb_pkg;

  // Which requester used the memory in the previous cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2,
    OWN_STORE = 2'd3
  } rv_arb_owner_t;

  // Width of the consecutive-data-grant run counter.
  localparam int RV_ARB_RUN_W = 4;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] rv_arb_word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv_arb_run_cnt.sv
// Saturating run counter for the arbiter starvation guard.
// Counts consecutive data grants; a fetch slot clears it. block_o asks the
// arbiter to hand the next slot to fetch once MAX_DATA_RUN grants in a row
// have gone to data.
module rv_arb_run_cnt
  import rv_arb_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic data_gnt_i,
  input  logic fetch_slot_i,
  output logic block_o
);

  localparam logic [RV_ARB_RUN_W-1:0] MAX_CNT = RV_ARB_RUN_W'(MAX_DATA_RUN);

  logic [RV_ARB_RUN_W-1:0] run_cnt_q;

  // Count data grants, clear on fetch, hold at the limit instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_cnt_q <= '0;
    end else if (fetch_slot_i) begin
      run_cnt_q <= '0;
    end else if (data_gnt_i && (run_cnt_q != MAX_CNT)) begin
      run_cnt_q <= run_cnt_q + 1'b1;
    end
  end

  // Block data once the run limit has been reached.
  always_comb begin
    block_o = (run_cnt_q == MAX_CNT);
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and the load/store unit.
// Data accesses win every collision; fetch sees a lost slot as im_valid_o = 0
// one cycle later and simply re-presents its address.
// Optional starvation guard: define RV_ARB_FAIRNESS_EN to force one fetch
// slot after MAX_DATA_RUN consecutive data grants.
//
// state     | meaning
// ----------+----------------------------------------------------------
// OWN_NONE  | reset; nothing was accessed last cycle, no result pending
// OWN_FETCH | fetch used the memory last cycle; instruction word on rdata
// OWN_LOAD  | a load used the memory last cycle; load data on rdata
// OWN_STORE | a store used the memory last cycle; nothing to return
module rv_mem_arbiter
  import rv_arb_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] im_addr_i,
  output logic [31:0] im_data_o,
  output logic        im_valid_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [3:0]  dm_be_i,
  output logic        dm_gnt_o,
  output logic [31:0] dm_rdata_o,
  output logic        dm_rvalid_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_we_o,
  input  logic [31:0] mem_rdata_i
);

  rv_arb_owner_t owner_q, owner_d;
  logic          data_block;
  logic          data_sel;
  logic [31:0]   addr_sel;

`ifdef RV_ARB_FAIRNESS_EN
  rv_arb_run_cnt #(
    .MAX_DATA_RUN (MAX_DATA_RUN)
  ) u_run_cnt (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .data_gnt_i   (data_sel),
    .fetch_slot_i (!data_sel),
    .block_o      (data_block)
  );
`else
  // Strict data priority: the limit is only meaningful with the guard built in.
  logic unused_max_data_run;
  assign unused_max_data_run = ^MAX_DATA_RUN;
  assign data_block = 1'b0;
`endif

  // Slot owner register; async reset drops any result still in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Pick this cycle's owner and drive the SRAM request side.
  always_comb begin
    data_sel    = 1'b0;
    addr_sel    = im_addr_i;
    owner_d     = OWN_FETCH;
    dm_gnt_o    = 1'b0;
    mem_we_o    = 4'b0000;
    mem_wdata_o = 32'h0;
    if (dm_req_i && !data_block) begin
      data_sel    = 1'b1;
      addr_sel    = dm_addr_i;
      dm_gnt_o    = 1'b1;
      mem_wdata_o = dm_wdata_i;
      if (dm_we_i) begin
        mem_we_o = dm_be_i;
        owner_d  = OWN_STORE;
      end else begin
        owner_d  = OWN_LOAD;
      end
    end
    mem_addr_o = rv_arb_word_align(addr_sel);
  end

  // Route the returning word and flag it for whoever owned the last slot.
  always_comb begin
    im_data_o   = mem_rdata_i;
    dm_rdata_o  = mem_rdata_i;
    im_valid_o  = (owner_q == OWN_FETCH);
    dm_rvalid_o = (owner_q == OWN_LOAD);
  end

  // Low address bits never reach the SRAM.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_sel[1:0];

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter: a vector table for single-cycle
// behaviour plus hand sequences for the long data run and async reset.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_rv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        im_valid;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt;
  logic [31:0] dm_rdata;
  logic        dm_rvalid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  rv_mem_arbiter #(.MAX_DATA_RUN(4)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .im_addr_i   (im_addr),
    .im_data_o   (im_data),
    .im_valid_o  (im_valid),
    .dm_req_i    (dm_req),
    .dm_we_i     (dm_we),
    .dm_addr_i   (dm_addr),
    .dm_wdata_i  (dm_wdata),
    .dm_be_i     (dm_be),
    .dm_gnt_o    (dm_gnt),
    .dm_rdata_o  (dm_rdata),
    .dm_rvalid_o (dm_rvalid),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM stand-in: 1-cycle read of an address-derived pattern.
  function automatic logic [31:0] sram_fn(input logic [31:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    return {~lo, lo};
  endfunction

  always @(posedge clk) mem_rdata <= sram_fn(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] im_addr;
    logic        e_gnt;
    logic [31:0] e_mem_addr;
    logic [3:0]  e_we;
    logic [31:0] e_wdata;
    logic        e_im_valid;
    logic        e_rvalid;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] prev_addr;
    logic        prev_fetch;
    logic [11:0] pat;

    // req we  addr          wdata          be      im_addr   gnt mem_addr     we      wdata          imv rv
    vecs[0]  = '{0, 0, 32'h0,        32'h0,        4'h0, 32'h000, 0, 32'h000,  4'h0, 32'h0,        0, 0};
    vecs[1]  = '{0, 0, 32'h0,        32'h0,        4'h0, 32'h004, 0, 32'h004,  4'h0, 32'h0,        1, 0};
    vecs[2]  = '{1, 0, 32'h2004,     32'h0,        4'h0, 32'h100, 1, 32'h2004, 4'h0, 32'h0,        1, 0};
    vecs[3]  = '{0, 0, 32'h0,        32'h0,        4'h0, 32'h100, 0, 32'h100,  4'h0, 32'h0,        0, 1};
    vecs[4]  = '{1, 1, 32'h3002,     32'hDEADBEEF, 4'h3, 32'h104, 1, 32'h3000, 4'h3, 32'hDEADBEEF, 1, 0};
    vecs[5]  = '{0, 0, 32'h0,        32'h0,        4'h0, 32'h104, 0, 32'h104,  4'h0, 32'h0,        0, 0};
    vecs[6]  = '{1, 0, 32'h40,       32'h0,        4'hF, 32'h108, 1, 32'h040,  4'h0, 32'h0,        1, 0};
    vecs[7]  = '{1, 1, 32'h44,       32'h12345678, 4'hF, 32'h108, 1, 32'h044,  4'hF, 32'h12345678, 0, 1};
    vecs[8]  = '{1, 0, 32'h4B,       32'h0,        4'h0, 32'h108, 1, 32'h048,  4'h0, 32'h0,        0, 0};
    vecs[9]  = '{0, 0, 32'h0,        32'h0,        4'h0, 32'h10B, 0, 32'h108,  4'h0, 32'h0,        0, 1};
    vecs[10] = '{0, 0, 32'h0,        32'h0,        4'h0, 32'h10C, 0, 32'h10C,  4'h0, 32'h0,        1, 0};

    rst_n = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0;
    dm_wdata = '0; dm_be = '0; im_addr = '0;

    // Held in reset across clock edges: nothing may be valid.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_im_valid", {31'b0, im_valid}, 32'h0);
    chk("reset_rvalid", {31'b0, dm_rvalid}, 32'h0);

    // Single-cycle vector table, starting on the release edge.
    prev_addr = '0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rst_n    = 1'b1;
      dm_req   = vecs[i].req;
      dm_we    = vecs[i].we;
      dm_addr  = vecs[i].addr;
      dm_wdata = vecs[i].wdata;
      dm_be    = vecs[i].be;
      im_addr  = vecs[i].im_addr;
      #1;
      chk($sformatf("v%0d_gnt", i), {31'b0, dm_gnt}, {31'b0, vecs[i].e_gnt});
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_mem_addr);
      chk($sformatf("v%0d_mem_we", i), {28'b0, mem_we}, {28'b0, vecs[i].e_we});
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_im_valid", i), {31'b0, im_valid}, {31'b0, vecs[i].e_im_valid});
      chk($sformatf("v%0d_rvalid", i), {31'b0, dm_rvalid}, {31'b0, vecs[i].e_rvalid});
      if (vecs[i].e_im_valid) chk($sformatf("v%0d_im_data", i), im_data, sram_fn(prev_addr));
      if (vecs[i].e_rvalid) chk($sformatf("v%0d_dm_rdata", i), dm_rdata, sram_fn(prev_addr));
      prev_addr = vecs[i].e_mem_addr;
    end

    // Twelve cycles of continuous loads; bit i = 1 means data owns cycle i.
`ifdef RV_ARB_FAIRNESS_EN
    pat = 12'b1101_1110_1111;
`else
    pat = 12'hFFF;
`endif
    prev_fetch = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_be = 4'h0;
      dm_wdata = 32'h0; im_addr = 32'h300;
      #1;
      chk($sformatf("run%0d_gnt", i), {31'b0, dm_gnt}, {31'b0, pat[i]});
      chk($sformatf("run%0d_mem_addr", i), mem_addr, pat[i] ? 32'h200 : 32'h300);
      chk($sformatf("run%0d_im_valid", i), {31'b0, im_valid}, {31'b0, prev_fetch});
      chk($sformatf("run%0d_rvalid", i), {31'b0, dm_rvalid}, {31'b0, !prev_fetch});
      prev_fetch = !pat[i];
    end

    // Load granted, then reset asserted before the next edge.
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2008; im_addr = 32'h400;
`ifdef RV_ARB_FAIRNESS_EN
    // Run ended two grants deep; this grant is still allowed.
`endif
    #1;
    chk("rst_load_gnt", {31'b0, dm_gnt}, 32'h1);
    @(posedge clk);
    #1;
    dm_req = 1'b0;
    chk("rst_pre_rvalid", {31'b0, dm_rvalid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_rvalid", {31'b0, dm_rvalid}, 32'h0);
    chk("rst_async_im_valid", {31'b0, im_valid}, 32'h0);
    chk("rst_mem_we_idle", {28'b0, mem_we}, 32'h0);

    // Release and confirm fetch resumes one cycle after the first slot.
    @(negedge clk);
    rst_n = 1'b1; im_addr = 32'h500;
    #1;
    chk("post_rst_im_valid0", {31'b0, im_valid}, 32'h0);
    chk("post_rst_mem_addr", mem_addr, 32'h500);
    @(negedge clk);
    im_addr = 32'h504;
    #1;
    chk("post_rst_im_valid1", {31'b0, im_valid}, 32'h1);
    chk("post_rst_im_data", im_data, sram_fn(32'h500));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
